// File: rtl/ysyx_22040237_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   RegWidth   : default address/data width of the core
//   StarveCntW : width of the IFU starvation counter (STARVE_MAX <= 15)
//   arb_state_e: transaction FSM encoding
//   arb_owner_e: which requester owns the in-flight transaction
package ysyx_22040237_mem_arb_pkg;

    localparam int unsigned RegWidth   = 64;
    localparam int unsigned StarveCntW = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnIfu = 1'b0,
        OwnLsu = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_22040237_arb_prio.sv
// Two-way grant with fixed LSU priority and an IFU anti-starvation counter.
//   clk, rst     : clock, asynchronous active-high reset
//   idle_i       : arbiter is idle and may grant this cycle
//   ifu_valid_i  : IFU request pending
//   lsu_valid_i  : LSU request pending
//   grant_ifu_o  : IFU wins this cycle
//   grant_lsu_o  : LSU wins this cycle
module ysyx_22040237_arb_prio
    import ysyx_22040237_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
    output logic grant_ifu_o,
    output logic grant_lsu_o
);

    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_MAX);

    logic [StarveCntW-1:0] cnt_q, cnt_d;
    logic                  ifu_prio;

    // IFU overrides the LSU only once it has lost STARVE_MAX contended rounds.
    assign ifu_prio    = (cnt_q == StarveMax);
    assign grant_lsu_o = idle_i & lsu_valid_i & ~(ifu_valid_i & ifu_prio);
    assign grant_ifu_o = idle_i & ifu_valid_i & (~lsu_valid_i | ifu_prio);

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ifu_o) begin
            cnt_d = '0;
        end else if (grant_lsu_o && ifu_valid_i && (cnt_q != StarveMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_22040237_mem_arb.sv
// Shares one memory port between the IFU (reads) and the LSU (reads/writes).
// One transaction in flight: IDLE (grant) -> ISSUE -> WAIT -> RESP -> IDLE.
//   clk, rst        : clock, asynchronous active-high reset
//   ifu_req_*/ifu_* : IFU read request (valid/ready) and response pulse + data
//   lsu_req_*/lsu_* : LSU request (valid/ready, wen/addr/wdata/wmask), response
//   mem_req_*/mem_* : downstream request (valid/ready) and response
//   proto_err_o     : sticky, set by a memory response outside WAIT
module ysyx_22040237_mem_arb
    import ysyx_22040237_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = RegWidth,
    parameter int unsigned DATA_W     = RegWidth,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_rsp_valid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic                lsu_wen_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_rsp_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_wen_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                proto_err_o
);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                proto_err_q, proto_err_d;
    logic                grant_ifu, grant_lsu;
    logic                issue;

    ysyx_22040237_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk         (clk),
        .rst         (rst),
        .idle_i      (state_q == StIdle),
        .ifu_valid_i (ifu_req_valid_i),
        .lsu_valid_i (lsu_req_valid_i),
        .grant_ifu_o (grant_ifu),
        .grant_lsu_o (grant_lsu)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        proto_err_d = proto_err_q | (mem_rsp_valid_i & (state_q != StWait));
        unique case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    state_d = StIssue;
                    owner_d = OwnLsu;
                    addr_d  = lsu_addr_i;
                    wen_d   = lsu_wen_i;
                    wdata_d = lsu_wdata_i;
                    wmask_d = lsu_wen_i ? lsu_wmask_i : '0;
                end else if (grant_ifu) begin
                    state_d = StIssue;
                    owner_d = OwnIfu;
                    addr_d  = ifu_addr_i;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            StIssue: begin
                if (mem_req_ready_i) state_d = StWait;
            end
            StWait: begin
                if (mem_rsp_valid_i) begin
                    state_d = StResp;
                    // Writes acknowledge with zero data.
                    if (owner_q == OwnLsu) begin
                        lsu_rdata_d = wen_q ? '0 : mem_rdata_i;
                    end else begin
                        ifu_rdata_d = mem_rdata_i;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIfu;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Readies are gated by rst so a requester held valid through reset sees no grant.
    assign ifu_req_ready_o = grant_ifu & ~rst;
    assign lsu_req_ready_o = grant_lsu & ~rst;

    assign issue           = (state_q == StIssue);
    assign mem_req_valid_o = issue;
    assign mem_wen_o       = issue & wen_q;
    assign mem_addr_o      = issue ? addr_q  : '0;
    assign mem_wdata_o     = issue ? wdata_q : '0;
    assign mem_wmask_o     = issue ? wmask_q : '0;

    assign ifu_rsp_valid_o = (state_q == StResp) & (owner_q == OwnIfu);
    assign lsu_rsp_valid_o = (state_q == StResp) & (owner_q == OwnLsu);
    assign ifu_rdata_o     = ifu_rdata_q;
    assign lsu_rdata_o     = lsu_rdata_q;
    assign proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
module tb_ysyx_22040237_mem_arb;

    logic        clk, rst;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
    logic [63:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_rsp_valid_o;
    logic [63:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [7:0]  lsu_wmask_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i, proto_err_o;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  mem_wmask_o;

    int total = 0;
    int bad   = 0;

    ysyx_22040237_mem_arb dut (
        .clk             (clk),
        .rst             (rst),
        .ifu_req_valid_i (ifu_req_valid_i),
        .ifu_req_ready_o (ifu_req_ready_o),
        .ifu_addr_i      (ifu_addr_i),
        .ifu_rsp_valid_o (ifu_rsp_valid_o),
        .ifu_rdata_o     (ifu_rdata_o),
        .lsu_req_valid_i (lsu_req_valid_i),
        .lsu_req_ready_o (lsu_req_ready_o),
        .lsu_wen_i       (lsu_wen_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_wmask_i     (lsu_wmask_i),
        .lsu_rsp_valid_o (lsu_rsp_valid_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_wen_o       (mem_wen_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wmask_o     (mem_wmask_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i),
        .proto_err_o     (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ifu_v;
        logic        lsu_v;
        logic        wen;
        logic [63:0] ifu_addr;
        logic [63:0] lsu_addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] mem_rdata;
        logic        exp_lsu;
        logic        exp_wen;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:4];

    function automatic vec_t mk(input logic ifu_v, input logic lsu_v, input logic wen,
                                input logic [63:0] ia, input logic [63:0] la,
                                input logic [63:0] wd, input logic [7:0] wm,
                                input logic [63:0] rd, input logic el, input logic ew,
                                input logic [63:0] ea, input logic [63:0] ewd,
                                input logic [7:0] ewm, input logic [63:0] er);
        vec_t v;
        v.ifu_v = ifu_v;  v.lsu_v = lsu_v;  v.wen = wen;
        v.ifu_addr = ia;  v.lsu_addr = la;  v.wdata = wd;  v.wmask = wm;
        v.mem_rdata = rd; v.exp_lsu = el;   v.exp_wen = ew;
        v.exp_addr = ea;  v.exp_wdata = ewd; v.exp_wmask = ewm; v.exp_rdata = er;
        return v;
    endfunction

    // Read-only request; the winner's address goes out and its data comes back.
    function automatic vec_t mk_rd(input logic ifu_v, input logic lsu_v, input logic el,
                                   input logic [63:0] ia, input logic [63:0] la,
                                   input logic [63:0] rd);
        return mk(ifu_v, lsu_v, 1'b0, ia, la, 64'h0, 8'h0, rd, el, 1'b0,
                  el ? la : ia, 64'h0, 8'h0, rd);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid_i = 0; ifu_addr_i = 0;
        lsu_req_valid_i = 0; lsu_wen_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; lsu_wmask_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Full transaction with an immediately ready memory that answers one cycle later.
    // Entered and left with the DUT in IDLE, 1 time unit after a rising edge.
    task automatic txn(input vec_t v, input bit hold, input string tag);
        ifu_req_valid_i = v.ifu_v;  ifu_addr_i  = v.ifu_addr;
        lsu_req_valid_i = v.lsu_v;  lsu_wen_i   = v.wen;   lsu_addr_i = v.lsu_addr;
        lsu_wdata_i     = v.wdata;  lsu_wmask_i = v.wmask;
        mem_req_ready_i = 1;
        #1;
        chk($sformatf("%s ifu_ready", tag), ifu_req_ready_o, !v.exp_lsu);
        chk($sformatf("%s lsu_ready", tag), lsu_req_ready_o, v.exp_lsu);
        tick();
        if (!hold) begin
            ifu_req_valid_i = 0;
            lsu_req_valid_i = 0;
        end
        #1;
        chk($sformatf("%s issue valid", tag), mem_req_valid_o, 1);
        chk($sformatf("%s issue wen", tag), mem_wen_o, v.exp_wen);
        chk($sformatf("%s issue addr", tag), mem_addr_o, v.exp_addr);
        chk($sformatf("%s issue wdata", tag), mem_wdata_o, v.exp_wdata);
        chk($sformatf("%s issue wmask", tag), mem_wmask_o, v.exp_wmask);
        chk($sformatf("%s issue readys", tag), {ifu_req_ready_o, lsu_req_ready_o}, 0);
        tick();
        mem_rsp_valid_i = 1;
        mem_rdata_i     = v.mem_rdata;
        #1;
        chk($sformatf("%s wait valid", tag), mem_req_valid_o, 0);
        chk($sformatf("%s wait rsp", tag), {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        tick();
        mem_rsp_valid_i = 0;
        mem_rdata_i     = 0;
        #1;
        chk($sformatf("%s ifu_rsp", tag), ifu_rsp_valid_o, !v.exp_lsu);
        chk($sformatf("%s lsu_rsp", tag), lsu_rsp_valid_o, v.exp_lsu);
        if (v.exp_lsu) chk($sformatf("%s lsu_rdata", tag), lsu_rdata_o, v.exp_rdata);
        else           chk($sformatf("%s ifu_rdata", tag), ifu_rdata_o, v.exp_rdata);
        chk($sformatf("%s resp readys", tag), {ifu_req_ready_o, lsu_req_ready_o}, 0);
        tick();
        chk($sformatf("%s rsp single", tag), {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk_rd(1, 0, 0, 64'h8000_0000, 64'h0, 64'h1234);
        vecs[1] = mk(0, 1, 0, 64'h0, 64'h8000_0008, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF,
                     1, 0, 64'h8000_0008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
        vecs[2] = mk(0, 1, 1, 64'h0, 64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 64'h5555,
                     1, 1, 64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 64'h0);
        vecs[3] = mk_rd(1, 1, 1, 64'h8000_0100, 64'h8000_0200, 64'h77);
        vecs[4] = mk(1, 0, 1, 64'h8000_0004, 64'h0, 64'hFFFF, 8'hFF, 64'hABCD,
                     0, 0, 64'h8000_0004, 64'h0, 8'h00, 64'hABCD);

        // Reset values
        rst = 1;
        clear_inputs();
        #2;
        chk("rst readys", {ifu_req_ready_o, lsu_req_ready_o}, 0);
        chk("rst rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        chk("rst mem_valid", mem_req_valid_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst rdata", ifu_rdata_o | lsu_rdata_o, 0);
        chk("rst proto_err", proto_err_o, 0);
        do_reset();

        // Table vectors
        for (int i = 0; i < 5; i++) txn(vecs[i], 0, $sformatf("vec%0d", i));

        // LSU write with a three-cycle memory stall
        do_reset();
        lsu_req_valid_i = 1; lsu_wen_i = 1; lsu_addr_i = 64'h8000_0010;
        lsu_wdata_i = 64'hDEAD_BEEF; lsu_wmask_i = 8'h0F;
        #1;
        chk("stall lsu_ready", lsu_req_ready_o, 1);
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready_i = 1;
            #1;
            chk($sformatf("stall%0d valid", i), mem_req_valid_o, 1);
            chk($sformatf("stall%0d wen", i), mem_wen_o, 1);
            chk($sformatf("stall%0d addr", i), mem_addr_o, 64'h8000_0010);
            chk($sformatf("stall%0d wdata", i), mem_wdata_o, 64'hDEAD_BEEF);
            chk($sformatf("stall%0d wmask", i), mem_wmask_o, 8'h0F);
            tick();
        end
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 64'h9999;
        tick();
        mem_rsp_valid_i = 0;
        #1;
        chk("stall lsu_rsp", lsu_rsp_valid_o, 1);
        chk("stall lsu_rdata", lsu_rdata_o, 0);
        chk("stall ifu_rsp", ifu_rsp_valid_o, 0);
        tick();
        chk("stall rsp end", lsu_rsp_valid_o, 0);

        // Continuous contention: LSU x4 then IFU, repeating
        do_reset();
        for (int k = 0; k < 10; k++) begin
            txn(mk_rd(1, 1, (k % 5) != 4, 64'h1000 + 64'(k), 64'h2000 + 64'(k), 64'h500 + 64'(k)),
                1, $sformatf("starve%0d", k));
        end
        clear_inputs();

        // Spurious memory response in IDLE
        do_reset();
        mem_rsp_valid_i = 1; mem_rdata_i = 64'hBAD;
        #1;
        chk("spur rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        tick();
        mem_rsp_valid_i = 0;
        #1;
        chk("spur err set", proto_err_o, 1);
        chk("spur rsp after", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        repeat (3) tick();
        chk("spur err sticky", proto_err_o, 1);
        txn(vecs[1], 0, "spur_txn");
        chk("spur err kept", proto_err_o, 1);

        // Asynchronous reset in the middle of WAIT
        do_reset();
        txn(vecs[0], 0, "prerst");
        ifu_req_valid_i = 1; ifu_addr_i = 64'h8000_0040; mem_req_ready_i = 1;
        tick();
        tick();
        #2;
        rst = 1;
        #1;
        chk("arst readys", {ifu_req_ready_o, lsu_req_ready_o}, 0);
        chk("arst rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        chk("arst ifu_rdata", ifu_rdata_o, 0);
        chk("arst mem", {mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, 0);
        chk("arst proto_err", proto_err_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
        mem_rsp_valid_i = 1; mem_rdata_i = 64'h4444;
        tick();
        mem_rsp_valid_i = 0;
        #1;
        chk("arst late rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        tick();
        chk("arst late rsp2", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        txn(vecs[4], 0, "postrst");

        // IFU drops valid while losing; solo LSU rounds must not advance the counter
        do_reset();
        txn(mk_rd(1, 1, 1, 64'h3000, 64'h3100, 64'h11), 0, "drop_both");
        for (int k = 0; k < 3; k++) begin
            txn(mk_rd(0, 1, 1, 64'h0, 64'h3200 + 64'(k), 64'h20 + 64'(k)), 0,
                $sformatf("drop_solo%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            txn(mk_rd(1, 1, k != 3, 64'h3300, 64'h3400 + 64'(k), 64'h30 + 64'(k)), 1,
                $sformatf("drop_cont%0d", k));
        end
        clear_inputs();
        txn(mk_rd(1, 0, 0, 64'h3500, 64'h0, 64'h40), 0, "drop_ifu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_mem_arb.md
Name: ysyx_22040237_mem_arb

Overview:
- Two-requester memory arbiter sharing one memory port between the IFU and the LSU in the multi-cycle core.
- The IFU issues read-only requests; the LSU issues both reads and writes.
- One transaction is in flight at a time, with registered request capture and a registered response return.
- Fixed LSU priority with an IFU anti-starvation counter.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (wmask width = DATA_W/8)
STARVE_MAX, 4, consecutive IFU losses before IFU is forced priority (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ifu_req_valid_i  in  1  IFU read request
ifu_req_ready_o  out  1  IFU request accepted this cycle
ifu_addr_i  in  ADDR_W  IFU read address
ifu_rsp_valid_o  out  1  IFU response pulse
ifu_rdata_o  out  DATA_W  IFU read data
lsu_req_valid_i  in  1  LSU request
lsu_req_ready_o  out  1  LSU request accepted this cycle
lsu_wen_i  in  1  1=write, 0=read
lsu_addr_i  in  ADDR_W  LSU address
lsu_wdata_i  in  DATA_W  LSU write data
lsu_wmask_i  in  DATA_W/8  LSU byte mask
lsu_rsp_valid_o  out  1  LSU response pulse (read data or write ack)
lsu_rdata_o  out  DATA_W  LSU read data (0 on write ack)
mem_req_valid_o  out  1  request to memory
mem_req_ready_i  in  1  memory accepts request
mem_wen_o  out  1  write enable
mem_addr_o  out  ADDR_W  address
mem_wdata_o  out  DATA_W  write data
mem_wmask_o  out  DATA_W/8  byte mask (0 on reads)
mem_rsp_valid_i  in  1  memory response
mem_rdata_i  in  DATA_W  memory read data
proto_err_o  out  1  sticky: mem_rsp_valid_i outside WAIT

Behaviour:
- Reset values: all outputs 0, state IDLE, starve counter 0, owner = none, latched request fields 0. Reset mid-transaction aborts it silently; no response is returned.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational from the valids.
  - If only one requester is valid, it is granted.
  - If both are valid, the LSU is granted unless starve_cnt == STARVE_MAX, in which case the IFU is granted.
  - The granted ready_o is high for exactly this cycle. The handshake is valid&ready.
  - On grant: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner; go to ISSUE.
- Starve counter:
  - +1 when both are valid in IDLE and the LSU wins, saturating at STARVE_MAX.
  - Cleared when the IFU is granted.
  - Unchanged otherwise.
- ISSUE:
  - mem_req_valid_o=1, with mem_* driven from the latched fields and stable until accepted.
  - On mem_req_ready_i, go to WAIT (same-cycle ready is allowed).
  - mem_* return to 0 outside ISSUE.
- WAIT:
  - On mem_rsp_valid_i, capture mem_rdata_i (forced to 0 for writes) and go to RESP.
- RESP:
  - Owner's rsp_valid_o=1 for exactly one cycle, with rdata_o valid that cycle; then IDLE.
  - rdata_o holds its value afterwards, but only counts while rsp_valid is high.
- Minimum latency: accept at cycle N, mem_req_valid_o at N+1, response at N+3 if the memory returns in the cycle after acceptance. Back-to-back throughput is one transaction per 4 cycles.
- Requesters hold valid until ready. Dropping valid before grant is legal; the request is simply not taken.
- mem_rsp_valid_i in IDLE/ISSUE/RESP is ignored and sets proto_err_o (cleared only by rst).
- Both ready_o signals are never high in the same cycle. Neither ready_o is high outside IDLE.

Decomposition:
- Shared package (ysyx_22040237 defines):
  - FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - width defaults `ysyx_22040237_REG_WIDTH
- One natural sub-module: ysyx_22040237_arb_prio. It is combinational 2-way grant plus the saturating starve counter register, and outputs grant_ifu/grant_lsu.

Test Plan:
- Single IFU read to 0x8000_0000; memory ready immediately, rsp next cycle, rdata 0x1234 -> ifu_req_ready_o at N, mem_req_valid_o at N+1 with wen=0/wmask=0, ifu_rsp_valid_o pulse at N+3 with 0x1234.
- LSU write to 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0x0F; mem_req_ready_i delayed 3 cycles -> mem_* stable across the stall, lsu_rsp_valid_o with rdata 0, no IFU response.
- IFU and LSU continuously valid, STARVE_MAX=4 -> grant sequence LSU,LSU,LSU,LSU,IFU repeating; never both readys in one cycle.
- Spurious mem_rsp_valid_i in IDLE -> proto_err_o goes to 1 and stays; no rsp_valid pulses; the next transaction still completes normally.
- rst asserted mid-WAIT (async, between edges) -> all outputs 0 immediately; a later mem_rsp_valid_i gives no rsp pulse; a new IFU request after reset completes.
- IFU valid drops in IDLE while LSU busy -> no grant to the IFU, starve counter unchanged, and the IFU is granted when it reasserts.
